// File: rtl/ctu_mask_id_ctl.sv
// ctu_mask_id_ctl
// Qualifies the 4-bit mask-programmable revision value after reset (or on a
// software request), freezes it into a shadow register and serves it as a
// JTAG IDCODE shift register and through a CSR req/ack read port.
//
// Ports:
//   clk_i          CTU clock
//   rst_i          synchronous reset, active high
//   mask_id_i      raw revision value from the strap cell
//   requal_req_i   one-cycle pulse: drop the shadow value and re-qualify
//   tap_capture_i  TAP Capture-DR with IDCODE selected
//   tap_shift_i    TAP Shift-DR with IDCODE selected
//   tap_tdi_i      serial data in
//   tap_tdo_o      serial data out (shift register bit 0)
//   csr_rd_req_i   CSR read request, level, held until ack
//   csr_rd_ack_o   one-cycle acknowledge
//   csr_rd_data_o  read data, non-zero only while ack is high
//   id_valid_o     shadow revision value is qualified
//   id_err_o       sticky: qualification timed out after 64 cycles
module ctu_mask_id_ctl #(
    parameter logic [15:0] PART_NUM   = 16'h0000,
    parameter logic [10:0] MFG_ID     = 11'h03E,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  mask_id_i,
    input  logic        requal_req_i,
    input  logic        tap_capture_i,
    input  logic        tap_shift_i,
    input  logic        tap_tdi_i,
    output logic        tap_tdo_o,
    input  logic        csr_rd_req_i,
    output logic        csr_rd_ack_o,
    output logic [31:0] csr_rd_data_o,
    output logic        id_valid_o,
    output logic        id_err_o
);

    localparam logic [3:0] STABLE_W = 4'(STABLE_CNT);
    localparam logic [6:0] TMO_LIM  = 7'd64;

    typedef enum logic {QUAL = 1'b0, VALID = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [3:0]  stab_q, stab_d;
    logic [3:0]  last_q, last_d;
    logic [6:0]  tmo_q, tmo_d;
    logic [3:0]  shadow_q, shadow_d;
    logic        err_q, err_d;
    logic [31:0] sr_q, sr_d;
    logic        ack_q, ack_d;
    logic [31:0] data_q, data_d;
    logic        served_q, served_d;

    logic        valid;
    logic [31:0] idcode_tap;

    assign valid      = (state_q == VALID);
    // TAP sees a zero revision field until the shadow value is qualified.
    assign idcode_tap = {(valid ? shadow_q : 4'h0), PART_NUM, MFG_ID, 1'b1};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= QUAL;
            stab_q   <= 4'h0;
            last_q   <= 4'h0;
            tmo_q    <= 7'd0;
            shadow_q <= 4'h0;
            err_q    <= 1'b0;
            sr_q     <= 32'h0;
            ack_q    <= 1'b0;
            data_q   <= 32'h0;
            served_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            stab_q   <= stab_d;
            last_q   <= last_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            sr_q     <= sr_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            served_q <= served_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        stab_d   = stab_q;
        last_d   = last_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        err_d    = err_q;

        case (state_q)
            QUAL: begin
                tmo_d = tmo_q + 7'd1;
                // A zero count means no sample taken yet: this one is sample 1.
                if (stab_q == 4'h0 || mask_id_i != last_q) begin
                    stab_d = 4'h1;
                    last_d = mask_id_i;
                end else if (stab_q != 4'hF) begin
                    stab_d = stab_q + 4'h1;
                end
                // Qualification wins over a timeout landing on the same edge.
                if (stab_d == STABLE_W) begin
                    state_d  = VALID;
                    shadow_d = last_d;
                    tmo_d    = 7'd0;
                end else if (tmo_d == TMO_LIM) begin
                    state_d  = VALID;
                    shadow_d = 4'hF;
                    err_d    = 1'b1;
                    tmo_d    = 7'd0;
                end
            end
            VALID: begin
                if (requal_req_i) begin
                    state_d  = QUAL;
                    stab_d   = 4'h0;
                    tmo_d    = 7'd0;
                    shadow_d = 4'h0;
                end
            end
            default: state_d = QUAL;
        endcase

        // TAP path: capture has priority over shift.
        sr_d = sr_q;
        if (tap_capture_i)
            sr_d = idcode_tap;
        else if (tap_shift_i)
            sr_d = {tap_tdi_i, sr_q[31:1]};

        // CSR path: one ack per request level; a re-qualification in the
        // same cycle defers the ack until the value is valid again.
        ack_d    = csr_rd_req_i && valid && !ack_q && !served_q && !requal_req_i;
        data_d   = ack_d ? {shadow_q, PART_NUM, MFG_ID, 1'b1} : 32'h0;
        served_d = csr_rd_req_i && (served_q || ack_d);
    end

    // Outputs
    always_comb begin
        tap_tdo_o     = sr_q[0];
        csr_rd_ack_o  = ack_q;
        csr_rd_data_o = data_q;
        id_valid_o    = valid;
        id_err_o      = err_q;
    end

endmodule
